adv7513_video_tgen: RTL and testbench

ADV7513_VIDEO_TGEN -- requirements
Module: adv7513_video_tgen

---
 rtl/adv7513_video_tgen.sv | 142 ++++++++++++++
 tb/tb_adv7513_video_tgen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adv7513_video_tgen.sv
// Video timing generator for the ADV7513 HDMI transmitter: raster counters,
// run/stop control, FIFO pop, two-stage aligned sync/DE/data outputs and underflow stats.
`timescale 1ns/1ps
module adv7513_video_tgen #(
  parameter int               PXL_W       = 24,
  parameter int               HVALID_W    = 1280,
  parameter int               HFP_W       = 110,
  parameter int               HSYNC_W     = 40,
  parameter int               HBP_W       = 220,
  parameter int               VVALID_W    = 720,
  parameter int               VFP_W       = 5,
  parameter int               VSYNC_W     = 5,
  parameter int               VBP_W       = 20,
  parameter bit               HS_ACT_HIGH = 1'b0,
  parameter bit               VS_ACT_HIGH = 1'b0,
  parameter logic [PXL_W-1:0] UFLOW_PXL   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             drvr_en,
  input  logic             ff_empty,
  input  logic [PXL_W-1:0] ff_rdata,
  output logic             ff_rd_en,
  input  logic             uflow_clr,
  output logic [PXL_W-1:0] HDMI_TX_D,
  output logic             HDMI_TX_DE,
  output logic             HDMI_TX_HS,
  output logic             HDMI_TX_VS,
  output logic             sof,
  output logic             busy,
  output logic [15:0]      uflow_cnt,
  output logic             uflow_sticky
);

  localparam int HTOTAL   = HFP_W + HSYNC_W + HBP_W + HVALID_W;
  localparam int VTOTAL   = VFP_W + VSYNC_W + VBP_W + VVALID_W;
  localparam int HW       = $clog2(HTOTAL);
  localparam int VW       = $clog2(VTOTAL);
  localparam int H_SYNC_S = HFP_W;
  localparam int H_BP_S   = HFP_W + HSYNC_W;
  localparam int H_VAL_S  = H_BP_S + HBP_W;
  localparam int V_SYNC_S = VFP_W;
  localparam int V_BP_S   = VFP_W + VSYNC_W;
  localparam int V_VAL_S  = V_BP_S + VBP_W;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t        state;
  logic [HW-1:0] hcntr;
  logic [VW-1:0] vcntr;
  logic          active, h_end, v_end;
  logic          h_val, v_val, h_sync, v_sync, valid_c;
  logic          de_p1, rd_p1, hs_p1, vs_p1, sof_p1;

  assign active  = (state != IDLE);
  assign h_end   = (hcntr == HW'(HTOTAL - 1));
  assign v_end   = (vcntr == VW'(VTOTAL - 1));
  assign h_val   = (hcntr >= HW'(H_VAL_S));
  assign v_val   = (vcntr >= VW'(V_VAL_S));
  assign h_sync  = (hcntr >= HW'(H_SYNC_S)) && (hcntr < HW'(H_BP_S));
  assign v_sync  = (vcntr >= VW'(V_SYNC_S)) && (vcntr < VW'(V_BP_S));
  assign valid_c = active && h_val && v_val;
  assign ff_rd_en = valid_c && !ff_empty;

  // STOP keeps the raster running so a frame always completes before IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      hcntr <= '0;
      vcntr <= '0;
    end else begin
      if (state == IDLE) begin
        hcntr <= '0;
        vcntr <= '0;
      end else begin
        hcntr <= h_end ? '0 : hcntr + 1'b1;
        if (h_end) vcntr <= v_end ? '0 : vcntr + 1'b1;
      end
      case (state)
        IDLE: if (drvr_en) begin
          state <= RUN;
          busy  <= 1'b1;
        end
        RUN: if (!drvr_en) state <= STOP;
        STOP: begin
          if (drvr_en) state <= RUN;
          else if (h_end && v_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1 lines up with the FIFO read latency; stage 2 drives the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_p1      <= 1'b0;
      rd_p1      <= 1'b0;
      sof_p1     <= 1'b0;
      hs_p1      <= ~HS_ACT_HIGH;
      vs_p1      <= ~VS_ACT_HIGH;
      HDMI_TX_DE <= 1'b0;
      HDMI_TX_HS <= ~HS_ACT_HIGH;
      HDMI_TX_VS <= ~VS_ACT_HIGH;
      HDMI_TX_D  <= '0;
      sof        <= 1'b0;
    end else begin
      de_p1      <= valid_c;
      rd_p1      <= ff_rd_en;
      sof_p1     <= active && (hcntr == '0) && (vcntr == '0);
      hs_p1      <= (active && h_sync) ? HS_ACT_HIGH : ~HS_ACT_HIGH;
      vs_p1      <= (active && v_sync) ? VS_ACT_HIGH : ~VS_ACT_HIGH;
      HDMI_TX_DE <= de_p1;
      HDMI_TX_HS <= hs_p1;
      HDMI_TX_VS <= vs_p1;
      sof        <= sof_p1;
      HDMI_TX_D  <= rd_p1 ? ff_rdata : (de_p1 ? UFLOW_PXL : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uflow_cnt    <= '0;
      uflow_sticky <= 1'b0;
    end else if (valid_c && ff_empty) begin
      uflow_sticky <= 1'b1;
      if (uflow_clr)               uflow_cnt <= 16'd1;
      else if (uflow_cnt != '1)    uflow_cnt <= uflow_cnt + 16'd1;
    end else if (uflow_clr) begin
      uflow_cnt    <= '0;
      uflow_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adv7513_video_tgen.sv
// Bench for adv7513_video_tgen: frame-position reference model, directed run/stop/underflow/reset
// scenarios, a randomized phase, and a dense-raster instance for counter saturation.
`timescale 1ns/1ps
module tb_adv7513_video_tgen;

  localparam int HV = 4, HF = 1, HS = 2, HB = 1;
  localparam int VV = 2, VF = 1, VS = 1, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] UPXL = 24'hABCDEF;
  localparam int ST = 128, SFRAME = ST * ST;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        sof;
    logic [23:0] d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, srst_n, drvr_en, ff_empty, uflow_clr;
  logic [23:0] ff_rdata = '0;
  int          fifo_seq = 1;

  logic        ff_rd_en, de0, hs0, vs0, sof0, busy0, ustk0;
  logic [23:0] d0;
  logic [15:0] ucnt0;
  logic        rd1, de1, hs1, vs1, sof1, busy1, ustk1;
  logic [23:0] d1;
  logic [15:0] ucnt1;
  logic        s_rd, s_de, s_hs, s_vs, s_sof, s_busy, s_stk;
  logic [23:0] s_d;
  logic [15:0] s_cnt;

  adv7513_video_tgen #(
    .PXL_W(24), .HVALID_W(HV), .HFP_W(HF), .HSYNC_W(HS), .HBP_W(HB),
    .VVALID_W(VV), .VFP_W(VF), .VSYNC_W(VS), .VBP_W(VB),
    .HS_ACT_HIGH(1'b0), .VS_ACT_HIGH(1'b0), .UFLOW_PXL(UPXL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .drvr_en(drvr_en), .ff_empty(ff_empty), .ff_rdata(ff_rdata),
    .ff_rd_en(ff_rd_en), .uflow_clr(uflow_clr), .HDMI_TX_D(d0), .HDMI_TX_DE(de0),
    .HDMI_TX_HS(hs0), .HDMI_TX_VS(vs0), .sof(sof0), .busy(busy0),
    .uflow_cnt(ucnt0), .uflow_sticky(ustk0)
  );

  adv7513_video_tgen #(
    .PXL_W(24), .HVALID_W(HV), .HFP_W(HF), .HSYNC_W(HS), .HBP_W(HB),
    .VVALID_W(VV), .VFP_W(VF), .VSYNC_W(VS), .VBP_W(VB),
    .HS_ACT_HIGH(1'b1), .VS_ACT_HIGH(1'b1), .UFLOW_PXL(UPXL)
  ) dut_pos (
    .clk(clk), .rst_n(rst_n), .drvr_en(drvr_en), .ff_empty(ff_empty), .ff_rdata(ff_rdata),
    .ff_rd_en(rd1), .uflow_clr(uflow_clr), .HDMI_TX_D(d1), .HDMI_TX_DE(de1),
    .HDMI_TX_HS(hs1), .HDMI_TX_VS(vs1), .sof(sof1), .busy(busy1),
    .uflow_cnt(ucnt1), .uflow_sticky(ustk1)
  );

  adv7513_video_tgen #(
    .PXL_W(24), .HVALID_W(125), .HFP_W(1), .HSYNC_W(1), .HBP_W(1),
    .VVALID_W(125), .VFP_W(1), .VSYNC_W(1), .VBP_W(1),
    .HS_ACT_HIGH(1'b0), .VS_ACT_HIGH(1'b0), .UFLOW_PXL(UPXL)
  ) dut_sat (
    .clk(clk), .rst_n(srst_n), .drvr_en(1'b1), .ff_empty(1'b1), .ff_rdata(24'h0),
    .ff_rd_en(s_rd), .uflow_clr(1'b0), .HDMI_TX_D(s_d), .HDMI_TX_DE(s_de),
    .HDMI_TX_HS(s_hs), .HDMI_TX_VS(s_vs), .sof(s_sof), .busy(s_busy),
    .uflow_cnt(s_cnt), .uflow_sticky(s_stk)
  );

  always @(posedge clk) begin
    if (ff_rd_en) begin
      ff_rdata <= fifo_seq[23:0];
      fifo_seq <= fifo_seq + 1;
    end
  end

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame position as a single index, outputs delayed by two entries.
  exp_t p1, p2;
  bit   m_active, m_prev_en, m_ustk;
  int   m_pos, m_ucnt, m_seq = 1;
  bit   s_active;
  int   s_pos, s_ucnt;
  int   cyc = 0, last_sof = 0, prev_sof = 0;

  function automatic bit in_rng(input int x, input int lo, input int n);
    return (x >= lo) && (x < lo + n);
  endfunction

  task automatic model_reset();
    m_active = 0; m_prev_en = 0; m_pos = 0; m_ucnt = 0; m_ustk = 0;
    p1 = '0; p2 = '0;
  endtask

  task automatic step();
    exp_t cur;
    bit   de_c, rd_c;
    int   h, v;
    @(negedge clk);
    cyc++;
    chk("de", 32'(de0), 32'(p2.de));
    chk("hs", 32'(hs0), 32'(!p2.hs));
    chk("vs", 32'(vs0), 32'(!p2.vs));
    chk("hs_pos", 32'(hs1), 32'(p2.hs));
    chk("vs_pos", 32'(vs1), 32'(p2.vs));
    chk("sof", 32'(sof0), 32'(p2.sof));
    chk("data", 32'(d0), 32'(p2.d));
    chk("busy", 32'(busy0), 32'(m_active));
    chk("ucnt", 32'(ucnt0), 32'(m_ucnt));
    chk("ustk", 32'(ustk0), 32'(m_ustk));
    if (sof0) begin prev_sof = last_sof; last_sof = cyc; end
    h = m_pos % HT;
    v = m_pos / HT;
    de_c = rst_n && m_active && in_rng(h, HF + HS + HB, HV) && in_rng(v, VF + VS + VB, VV);
    rd_c = de_c && !ff_empty;
    chk("rd_en", 32'(ff_rd_en), 32'(rd_c));
    if (!rst_n) model_reset();
    else begin
      cur.de  = de_c;
      cur.hs  = m_active && in_rng(h, HF, HS);
      cur.vs  = m_active && in_rng(v, VF, VS);
      cur.sof = m_active && (m_pos == 0);
      cur.d   = rd_c ? m_seq[23:0] : (de_c ? UPXL : 24'h0);
      if (rd_c) m_seq++;
      p2 = p1;
      p1 = cur;
      if (de_c && ff_empty) begin
        m_ucnt = uflow_clr ? 1 : ((m_ucnt < 65535) ? m_ucnt + 1 : 65535);
        m_ustk = 1;
      end else if (uflow_clr) begin
        m_ucnt = 0;
        m_ustk = 0;
      end
      // Shut down only at the last pixel after en has stayed low for two cycles.
      if (!m_active) begin
        if (drvr_en) m_active = 1;
      end else if (m_pos == FRAME - 1 && !drvr_en && !m_prev_en) begin
        m_active = 0;
        m_pos = 0;
      end else m_pos = (m_pos + 1) % FRAME;
      m_prev_en = drvr_en;
    end
    if (s_ucnt >= 65530)
      chk("sat_cnt", 32'(s_cnt), 32'((s_ucnt > 65535) ? 65535 : s_ucnt));
    if (!srst_n) begin
      s_active = 0; s_pos = 0; s_ucnt = 0;
    end else if (!s_active) s_active = 1;
    else begin
      if ((s_pos % ST) >= 3 && (s_pos / ST) >= 3) s_ucnt++;
      s_pos = (s_pos + 1) % SFRAME;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pos(input int p);
    int guard = 0;
    while (!(m_active && m_pos == p) && guard < 4 * FRAME) begin
      step();
      guard++;
    end
  endtask

  initial begin
    rst_n = 0; srst_n = 0; drvr_en = 0; ff_empty = 0; uflow_clr = 0;
    model_reset();
    s_active = 0; s_pos = 0; s_ucnt = 0;
    @(posedge clk);
    #1;
    chk("rst_de", 32'(de0), 32'd0);
    chk("rst_hs", 32'(hs0), 32'd1);
    chk("rst_hs_pos", 32'(hs1), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    run(2);
    rst_n = 1; srst_n = 1;
    run(3);

    drvr_en = 1;
    run(130);
    chk("sof_period", 32'(last_sof - prev_sof), 32'd40);

    wait_pos(10);
    drvr_en = 0;
    run(60);
    chk("stop_busy", 32'(busy0), 32'd0);
    chk("stop_de", 32'(de0), 32'd0);

    drvr_en = 1;
    step();
    wait_pos(10);
    drvr_en = 0;
    wait_pos(20);
    drvr_en = 1;
    run(45);
    chk("restore_sof_gap", 32'(last_sof - prev_sof), 32'd40);

    uflow_clr = 1;
    step();
    uflow_clr = 0;
    wait_pos(28);
    ff_empty = 1;
    run(3);
    ff_empty = 0;
    chk("uflow_cnt3", 32'(ucnt0), 32'd3);
    chk("uflow_stk", 32'(ustk0), 32'd1);
    ff_empty = 1; uflow_clr = 1;
    step();
    ff_empty = 0; uflow_clr = 0;
    run(2);
    chk("clr_collide", 32'(ucnt0), 32'd1);
    uflow_clr = 1;
    step();
    uflow_clr = 0;
    run(8);
    chk("uflow_clr", 32'(ucnt0), 32'd0);
    chk("uflow_clr_stk", 32'(ustk0), 32'd0);

    wait_pos(11);
    rst_n = 0;
    #1;
    chk("mid_rst_hs", 32'(hs0), 32'd1);
    chk("mid_rst_vs", 32'(vs0), 32'd1);
    chk("mid_rst_hs_pos", 32'(hs1), 32'd0);
    chk("mid_rst_vs_pos", 32'(vs1), 32'd0);
    chk("mid_rst_de", 32'(de0), 32'd0);
    chk("mid_rst_d", 32'(d0), 32'd0);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_rd", 32'(ff_rd_en), 32'd0);
    model_reset();
    run(2);
    rst_n = 1;
    run(90);

    for (int i = 0; i < 1500; i++) begin
      if (($urandom % 20) == 0) drvr_en = ~drvr_en;
      ff_empty  = (($urandom % 8) == 0);
      uflow_clr = (($urandom % 32) == 0);
      step();
    end

    drvr_en = 1; ff_empty = 0; uflow_clr = 0;
    for (int g = 0; g < 90000 && s_ucnt < 65540; g++) step();
    chk("sat_hold", 32'(s_cnt), 32'hFFFF);
    chk("sat_stk", 32'(s_stk), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
